// File: rtl/dmem_arbiter_n.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_n
// Round-robin front end that lets NCORE processor cores share one single-port
// data RAM. Each core raises a level read/write request and holds it until
// it sees its one-cycle done pulse. One access is in flight at a time:
//   IDLE -> ISSUE -> (WAIT x RD_LAT, reads only) -> RESP -> IDLE
//
// Optional build macro: DMEM_ARB_COALESCE_EN
//   When defined, a granted read also serves every other pending read-only
//   request to the same address from the same RAM access.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   core_en_i    per-core enable; a disabled core is never granted
//   req_rd_i     per-core read request (rd+wr together means write)
//   req_wr_i     per-core write request
//   req_addr_i   flattened addresses, core i at [i*AW +: AW]
//   req_wdata_i  flattened write data, core i at [i*DW +: DW]
//   rdata_o      flattened registered read data per core
//   done_o       one-cycle completion pulse per core
//   mem_ren_o    RAM read enable  (ISSUE cycle of a read only)
//   mem_wen_o    RAM write enable (ISSUE cycle of a write only)
//   mem_addr_o   RAM address (0 outside ISSUE)
//   mem_wdata_o  RAM write data (0 unless writing)
//   mem_rdata_i  RAM read data, valid RD_LAT cycles after mem_ren_o
//   busy_o       high whenever the controller is not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter_n #(
    parameter int NCORE  = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NCORE-1:0]    core_en_i,
    input  logic [NCORE-1:0]    req_rd_i,
    input  logic [NCORE-1:0]    req_wr_i,
    input  logic [NCORE*AW-1:0] req_addr_i,
    input  logic [NCORE*DW-1:0] req_wdata_i,
    output logic [NCORE*DW-1:0] rdata_o,
    output logic [NCORE-1:0]    done_o,
    output logic                mem_ren_o,
    output logic                mem_wen_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    input  logic [DW-1:0]       mem_rdata_i,
    output logic                busy_o
);
    localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                op_wr_q, op_wr_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [NCORE-1:0]    mask_q, mask_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [NCORE*DW-1:0] rdata_q, rdata_d;
    logic [NCORE-1:0]    done_q, done_d;
    logic                mem_ren_q, mem_ren_d;
    logic                mem_wen_q, mem_wen_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic [NCORE-1:0]    pending_s;
    logic [PW-1:0]       cand_s;
    logic [PW-1:0]       grant_s;
    logic                grant_vld_s;
    logic                grant_wr_s;
    logic [AW-1:0]       gaddr_s;
    logic [DW-1:0]       gwdata_s;
    logic [NCORE-1:0]    serve_s;
    logic                capture_s;

    // (base + off) mod NCORE without a generic divider; off < NCORE always.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCORE) begin
            s = s - NCORE;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    // Round-robin pick starting at rr_ptr_q, plus the granted request's fields.
    always_comb begin
        pending_s   = core_en_i & (req_rd_i | req_wr_i);
        cand_s      = '0;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        for (int k = 0; k < NCORE; k++) begin
            cand_s = wrap_idx(rr_ptr_q, k);
            if (!grant_vld_s && pending_s[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_s     = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        grant_wr_s = 1'b0;
        gaddr_s    = '0;
        gwdata_s   = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (grant_s == PW'(i)) begin
                grant_wr_s = req_wr_i[i];
                gaddr_s    = req_addr_i[i*AW +: AW];
                gwdata_s   = req_wdata_i[i*DW +: DW];
            end else begin
                grant_wr_s = grant_wr_s;
            end
        end
        serve_s          = '0;
        serve_s[grant_s] = 1'b1;
`ifdef DMEM_ARB_COALESCE_EN
        // Piggy-back other read-only requests to the granted read address.
        for (int i = 0; i < NCORE; i++) begin
            if (!grant_wr_s && pending_s[i] && req_rd_i[i] && !req_wr_i[i] &&
                (req_addr_i[i*AW +: AW] == gaddr_s)) begin
                serve_s[i] = 1'b1;
            end else begin
                serve_s[i] = serve_s[i];
            end
        end
`endif
    end

    // Next-state logic and latching of the granted transaction.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        wcnt_d    = wcnt_q;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    state_d  = S_ISSUE;
                    rr_ptr_d = (grant_s == PW'(NCORE - 1)) ? PW'(0) : grant_s + PW'(1);
                    op_wr_d  = grant_wr_s;
                    addr_d   = gaddr_s;
                    wdata_d  = gwdata_s;
                    mask_d   = serve_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = CW'(1);
                state_d = op_wr_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // wcnt_q counts cycles since ISSUE; data is valid at RD_LAT.
                if (wcnt_q == CW'(RD_LAT)) begin
                    capture_s = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so that
    // every output leaves a flop.
    always_comb begin
        mem_ren_d   = (state_d == S_ISSUE) && !op_wr_d;
        mem_wen_d   = (state_d == S_ISSUE) && op_wr_d;
        mem_addr_d  = (state_d == S_ISSUE) ? addr_d : '0;
        mem_wdata_d = mem_wen_d ? wdata_d : '0;
        done_d      = (state_d == S_RESP) ? mask_d : '0;
        busy_d      = (state_d != S_IDLE);
        rdata_d     = rdata_q;
        for (int i = 0; i < NCORE; i++) begin
            if (capture_s && mask_q[i]) begin
                rdata_d[i*DW +: DW] = mem_rdata_i;
            end else begin
                rdata_d[i*DW +: DW] = rdata_q[i*DW +: DW];
            end
        end
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            wcnt_q      <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_wr_q     <= op_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            wcnt_q      <= wcnt_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign mem_ren_o   = mem_ren_q;
    assign mem_wen_o   = mem_wen_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter_n.sv
// -----------------------------------------------------------------------------
// Testbench for dmem_arbiter_n (NCORE=4, AW=8, DW=8, RD_LAT=1).
// A transaction-level reference model predicts, for every cycle, the RAM
// strobes, done pulses, busy and per-core read data. RAM content defaults to
// addr+0x40 until written. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter_n;
    localparam int NCORE  = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NCORE-1:0]    core_en, req_rd, req_wr;
    logic [NCORE*AW-1:0] req_addr;
    logic [NCORE*DW-1:0] req_wdata;
    logic [NCORE*DW-1:0] rdata;
    logic [NCORE-1:0]    done;
    logic                mem_ren, mem_wen, busy;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata, mem_rdata;

    dmem_arbiter_n #(.NCORE(NCORE), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk_i(clk), .rst_i(rst), .core_en_i(core_en), .req_rd_i(req_rd),
        .req_wr_i(req_wr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rdata_o(rdata), .done_o(done), .mem_ren_o(mem_ren), .mem_wen_o(mem_wen),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    // RAM model: unwritten locations read as addr+0x40, RD_LAT-deep read pipe.
    logic          ram_clr;
    logic [DW-1:0] ram [256];
    logic [255:0]  ram_vld;
    logic [DW-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_clr) ram_vld <= '0;
        else if (mem_wen === 1'b1) begin
            ram[mem_addr]     <= mem_wdata;
            ram_vld[mem_addr] <= 1'b1;
        end
        rpipe[0] <= ram_vld[mem_addr] ? ram[mem_addr] : mem_addr + 8'h40;
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               cyc;
    bit               m_valid, m_active, m_wr;
    int               m_issue, m_resp, m_rr;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata, m_rdval;
    logic [NCORE-1:0] m_mask, drop_next;
    logic [DW-1:0]    exp_rd [NCORE];
    logic [DW-1:0]    exp_ram [256];
    logic [255:0]     exp_vld;

    // Observations for scenario-level checks
    logic [NCORE-1:0] obs_done_q [$];
    int ren_cnt, wen_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rd[i] = rd;
        req_wr[i] = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic arbitrate();
        logic [NCORE-1:0] pend;
        int g;
        pend = core_en & (req_rd | req_wr);
        g = -1;
        if (pend != '0) begin
            for (int k = 0; k < NCORE; k++)
                if (g < 0 && pend[(m_rr + k) % NCORE]) g = (m_rr + k) % NCORE;
            m_wr    = req_wr[g];
            m_addr  = req_addr[g*AW +: AW];
            m_wdata = req_wdata[g*DW +: DW];
            m_mask  = '0;
            m_mask[g] = 1'b1;
`ifdef DMEM_ARB_COALESCE_EN
            if (!m_wr)
                for (int j = 0; j < NCORE; j++)
                    if (pend[j] && req_rd[j] && !req_wr[j] && req_addr[j*AW +: AW] == m_addr)
                        m_mask[j] = 1'b1;
`endif
            m_rr = (g + 1) % NCORE;
            if (m_wr) begin
                exp_ram[m_addr] = m_wdata;
                exp_vld[m_addr] = 1'b1;
            end else begin
                m_rdval = exp_vld[m_addr] ? exp_ram[m_addr] : m_addr + 8'h40;
            end
            m_active = 1'b1;
            m_issue  = cyc + 1;
            m_resp   = cyc + 2 + (m_wr ? 0 : RD_LAT);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then
    // drop the requests of cores that just got their done pulse.
    task automatic step();
        logic [NCORE-1:0]    e_done;
        logic                e_ren, e_wen;
        logic [AW-1:0]       e_addr;
        logic [DW-1:0]       e_wdata;
        logic [NCORE*DW-1:0] e_rdata;
        @(negedge clk);
        e_done = '0; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
        if (m_active && cyc == m_issue) begin
            e_ren   = !m_wr;
            e_wen   = m_wr;
            e_addr  = m_addr;
            e_wdata = m_wr ? m_wdata : '0;
        end
        if (m_active && cyc == m_resp) begin
            e_done = m_mask;
            if (!m_wr)
                for (int i = 0; i < NCORE; i++) if (m_mask[i]) exp_rd[i] = m_rdval;
        end
        for (int i = 0; i < NCORE; i++) e_rdata[i*DW +: DW] = exp_rd[i];
        if (done !== '0) obs_done_q.push_back(done);
        if (mem_ren === 1'b1) ren_cnt++;
        if (mem_wen === 1'b1) wen_cnt++;
        if (m_valid) begin
            chk("mem_ren",   32'(mem_ren),   32'(e_ren));
            chk("mem_wen",   32'(mem_wen),   32'(e_wen));
            chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("done",      32'(done),      32'(e_done));
            chk("busy",      32'(busy),      32'(m_active));
            chk("rdata",     32'(rdata),     32'(e_rdata));
        end
        drop_next = '0;
        if (m_active && cyc == m_resp) drop_next = m_mask;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_rr     = 0;
            for (int i = 0; i < NCORE; i++) exp_rd[i] = '0;
        end else if (m_active) begin
            if (cyc == m_resp) m_active = 1'b0;
        end else begin
            arbitrate();
        end
        @(posedge clk);
        #1;
        cyc++;
        req_rd = req_rd & ~drop_next;
        req_wr = req_wr & ~drop_next;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_obs();
        obs_done_q.delete();
        ren_cnt = 0;
        wen_cnt = 0;
    endtask

    initial begin
        logic [AW-1:0] rr_addr [NCORE];
        int sz;
        cyc = 0; m_valid = 1'b0; m_active = 1'b0; m_rr = 0; m_wr = 1'b0;
        m_issue = 0; m_resp = 0; m_mask = '0; drop_next = '0;
        exp_vld = '0;
        for (int i = 0; i < NCORE; i++) exp_rd[i] = '0;
        clear_obs();

        // 1. Reset with every request raised, then first grant goes to core 0
        rst = 1'b1; ram_clr = 1'b1; core_en = '1;
        for (int i = 0; i < NCORE; i++) set_req(i, 1'b1, 1'b1, 8'(8'h80 + i), 8'(i + 1));
        step();
        ram_clr = 1'b0;
        step();
        rst = 1'b0;
        clear_obs();
        run(20);
        chk("t1_ndone", 32'(obs_done_q.size()), 32'd4);
        chk("t1_first_grant", 32'(obs_done_q[0]), 32'h1);

        // 2. Single write by core 2
        clear_obs();
        set_req(2, 1'b0, 1'b1, 8'h10, 8'hA5);
        run(6);
        chk("t2_ndone", 32'(obs_done_q.size()), 32'd1);
        chk("t2_done_core", 32'(obs_done_q[0]), 32'h4);
        chk("t2_wen_cnt", 32'(wen_cnt), 32'd1);

        // 3. Round-robin among cores 0, 1, 3 reading continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_obs();
        rr_addr[0] = 8'h01; rr_addr[1] = 8'h02; rr_addr[2] = 8'h00; rr_addr[3] = 8'h03;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NCORE; i++)
                if (i != 2 && !req_rd[i] && !drop_next[i]) set_req(i, 1'b1, 1'b0, rr_addr[i], 8'h00);
            step();
        end
        run(14);
        chk("t3_ndone_ge4", 32'(obs_done_q.size() >= 4), 32'd1);
        chk("t3_grant0", 32'(obs_done_q[0]), 32'h1);
        chk("t3_grant1", 32'(obs_done_q[1]), 32'h2);
        chk("t3_grant2", 32'(obs_done_q[2]), 32'h8);
        chk("t3_grant3", 32'(obs_done_q[3]), 32'h1);
        chk("t3_rdata0", 32'(rdata[0*DW +: DW]), 32'h41);
        chk("t3_rdata1", 32'(rdata[1*DW +: DW]), 32'h42);
        chk("t3_rdata3", 32'(rdata[3*DW +: DW]), 32'h43);

        // 4. All cores read the same address (0x7E stored there first)
        set_req(0, 1'b0, 1'b1, 8'h20, 8'h7E);
        run(6);
        clear_obs();
        for (int i = 0; i < NCORE; i++) set_req(i, 1'b1, 1'b0, 8'h20, 8'h00);
        run(24);
`ifdef DMEM_ARB_COALESCE_EN
        chk("t4_ren_cnt", 32'(ren_cnt), 32'd1);
        chk("t4_ndone", 32'(obs_done_q.size()), 32'd1);
        chk("t4_done_all", 32'(obs_done_q[0]), 32'hF);
`else
        chk("t4_ren_cnt", 32'(ren_cnt), 32'd4);
        chk("t4_ndone", 32'(obs_done_q.size()), 32'd4);
        sz = obs_done_q.size();
        for (int k = 0; k < sz; k++) chk("t4_done_single", 32'($countones(obs_done_q[k])), 32'd1);
`endif
        chk("t4_rdata_all", 32'(rdata), 32'h7E7E7E7E);

        // 5. rd+wr counts as write; disabled core 3 is never served
        clear_obs();
        core_en[3] = 1'b0;
        set_req(1, 1'b1, 1'b1, 8'h30, 8'h11);
        set_req(3, 1'b1, 1'b0, 8'h30, 8'h00);
        run(12);
        chk("t5_wen_cnt", 32'(wen_cnt), 32'd1);
        chk("t5_ren_cnt", 32'(ren_cnt), 32'd0);
        chk("t5_ndone", 32'(obs_done_q.size()), 32'd1);
        chk("t5_done_core1", 32'(obs_done_q[0]), 32'h2);
        req_rd[3] = 1'b0;
        core_en[3] = 1'b1;

        // 6. Reset while a read waits for RAM data
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        run(2);
        clear_obs();
        rst = 1'b1;
        req_rd[0] = 1'b0;
        step();
        rst = 1'b0;
        run(3);
        chk("t6_no_done", 32'(obs_done_q.size()), 32'd0);
        set_req(3, 1'b1, 1'b0, 8'h03, 8'h00);
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        run(12);
        chk("t6_ndone", 32'(obs_done_q.size()), 32'd2);
        chk("t6_rr_reset", 32'(obs_done_q[0]), 32'h1);

        // 7. Random traffic on a small address set to provoke coalescing
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NCORE; i++) begin
                if (!req_rd[i] && !req_wr[i] && !drop_next[i] && $urandom_range(0, 2) == 0) begin
                    int op;
                    op = int'($urandom_range(0, 3));
                    set_req(i, (op != 2), (op >= 2), 8'(8'h20 + $urandom_range(0, 3)), 8'($urandom));
                end
                if ($urandom_range(0, 39) == 0) core_en[i] = ~core_en[i];
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        core_en = '1;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter_n.md
Name: dmem_arbiter_n

Overview:
- Parametrised N-core data-memory controller: the next generation of the multi-core DRAM front end.
- Sits between NCORE processor cores and a single-port data RAM.
- Arbitrates independent per-core read/write requests round-robin.
- Optionally merges same-address reads into one RAM access.
- Returns read data and a one-cycle done pulse per core. Cores no longer need to issue memory operations in lockstep.

Parameters:
NCORE, 4, number of core ports (2..8)
AW, 8, address width
DW, 8, data width
RD_LAT, 1, RAM read latency in cycles from mem_ren high to mem_rdata valid (1..4)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous reset, active-high
core_en  input  NCORE  per-core enable; 0 = core inactive, its requests ignored
req_rd  input  NCORE  per-core read request, level, held until done
req_wr  input  NCORE  per-core write request, level, held until done
req_addr  input  NCORE*AW  flattened addresses, core i at [i*AW +: AW]
req_wdata  input  NCORE*DW  flattened write data
rdata  output  NCORE*DW  flattened per-core read data, registered
done  output  NCORE  one-cycle completion pulse per core
mem_ren  output  1  RAM read enable
mem_wen  output  1  RAM write enable
mem_addr  output  AW  RAM address
mem_wdata  output  DW  RAM write data
mem_rdata  input  DW  RAM read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high, wins over everything. State goes to IDLE and rr_ptr to 0. All outputs (rdata, done, mem_*, busy) go to 0. Any in-flight access is dropped with no done.
- pending[i] = core_en[i] & (req_rd[i] | req_wr[i]).
- If req_rd[i] and req_wr[i] are both high, the request is treated as a write.
- State machine: IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> RESP -> IDLE.
- IDLE:
  - If no pending request, stay in IDLE.
  - Otherwise grant g = the first pending index scanning rr_ptr, rr_ptr+1, … mod NCORE.
  - Latch the op type, addr[g] and wdata[g]. Set rr_ptr = (g+1) mod NCORE.
  - For a read, build serve_mask = {g} plus coalesced cores (see Optional Feature).
- ISSUE (one cycle): exactly one of mem_ren/mem_wen is high. mem_addr = latched address; mem_wdata = latched data for writes.
- Write: ISSUE -> RESP.
- Read: ISSUE -> WAIT. Stay in WAIT until the cycle that is RD_LAT cycles after ISSUE. In that cycle, capture mem_rdata into rdata of every core in serve_mask, then -> RESP.
- RESP (one cycle): done[i] = 1 for every i in serve_mask (writes: g only). rdata of other cores is unchanged. Next state IDLE.
- Latency from request sampled in IDLE (cycle 0): write done at cycle 2; read done at cycle 2+RD_LAT.
- Handshake: a core must drop its request in the cycle after done. IDLE never samples during RESP, so there is no double service.
- Request inputs are sampled only in IDLE. Changes during ISSUE/WAIT affect only later arbitration.
- core_en dropped mid-access: the access still completes and done is still pulsed.
- mem_ren and mem_wen are never high together. Both are 0 outside ISSUE.

Optional Feature:
- Macro DMEM_ARB_COALESCE_EN.
- Defined: in IDLE, every pending core whose request is read-only (req_rd=1, req_wr=0) with req_addr equal to the granted read address is added to serve_mask. All of them receive the same data and done in the same RESP cycle from a single mem_ren. rr_ptr still advances to g+1 only.
- Undefined: serve_mask = {g} always; each read costs its own RAM access.

Test Plan (NCORE=4, AW=8, DW=8, RD_LAT=1):
1. Reset: Rst high 2 cycles with all requests high -> all outputs 0, busy 0. After release, first grant goes to core 0.
2. Single write: core 2 writes addr 0x10, data 0xA5 -> mem_wen=1, mem_addr=0x10, mem_wdata=0xA5 in cycle 1; done[2] in cycle 2 only.
3. Round-robin: cores 0, 1 and 3 read 0x01, 0x02 and 0x03 continuously (RAM returns addr+0x40) -> grants in order 0, 1, 3, 0; rdata0=0x41, rdata1=0x42, rdata3=0x43; one done pulse per access.
4. Coalesce (macro on): all four cores read 0x20, RAM returns 0x7E -> exactly one mem_ren; done=4'b1111 in the same cycle; all rdata=0x7E. With the macro off -> four mem_ren pulses and four separate done pulses.
5. Mixed/disabled: core 1 has both rd and wr high at 0x30 (data 0x11); core_en[3]=0 while core 3 requests -> core 1 is serviced as a write; core 3 never gets a grant or done.
6. Reset mid-read: assert Rst during WAIT -> no done for the in-flight read; state goes to IDLE, rr_ptr to 0, mem_ren to 0 the next cycle.
